serial_divider: RTL and testbench
=================================

SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand, quotient and remainder width in bits (legal range 2..16).
REQ-002 SHALL have port CLOCK_50  input  1  meaning system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESETN  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  meaning request to begin one division; sampled only in IDLE.
REQ-005 SHALL have port A  input  N  meaning unsigned dividend, captured on the accepted START edge.
REQ-006 SHALL have port B  input  N  meaning unsigned divisor, captured on the accepted START edge.
REQ-007 SHALL have port Q  output  N  meaning quotient, registered.
REQ-008 SHALL have port R  output  N  meaning remainder, registered.
REQ-009 SHALL have port BUSY  output  1  meaning high while in LOAD or CALC.
REQ-010 SHALL have port DONE  output  1  meaning one-cycle pulse when Q/R/ERR become valid.
REQ-011 SHALL have port ERR  output  1  meaning divide-by-zero flag, valid with DONE, held until the next accepted START.

Function
REQ-012 SHALL implement states IDLE, LOAD, CALC, FIN; IDLE->LOAD on START=1; LOAD->CALC always; CALC->FIN after N iterations; FIN->IDLE always.
REQ-013 SHALL, in LOAD, set internal partial remainder P (N+1 bits) to 0, shift register to A, latched divisor to B and iteration counter to 0.
REQ-014 SHALL, per CALC cycle, shift {P,shift register} left by one, then, if P>=divisor, subtract divisor from P and set shift register bit 0 to 1, else set it to 0.
REQ-015 SHALL, in FIN, load Q from the shift register and R from P[N-1:0], and assert DONE for exactly that cycle.
REQ-016 SHALL make latency fixed: START sampled high at edge k gives DONE high in the cycle following edge k+N+2; total N+3 cycles from START through FIN.
REQ-017 SHALL hold BUSY high from the cycle after the accepted START through the last CALC cycle; BUSY SHALL be low in FIN and IDLE.
REQ-018 SHALL ignore START while BUSY=1 or in FIN; A/B changes after capture SHALL not affect the result.
REQ-019 SHALL keep Q, R and ERR stable from FIN until the next accepted START; ERR SHALL clear on accepted START.
REQ-020 SHALL accept START in IDLE on the cycle directly after FIN, allowing back-to-back divisions.
REQ-021 SHALL produce, without the trap feature, for B=0 the natural restoring result Q=all ones, R=A, ERR=0.

Reset
REQ-022 SHALL, on RESETN low, immediately force state IDLE, Q=0, R=0, BUSY=0, DONE=0, ERR=0, and clear internal registers, regardless of current state.
REQ-023 SHALL abandon any division in progress on reset, with no DONE pulse after RESETN deasserts.
REQ-024 SHALL accept START on the first rising edge after RESETN goes high.

Configuration
REQ-025 SHALL provide macro SERIAL_DIVIDER_ZERO_TRAP_EN; when defined, B=0 at START SHALL go IDLE->FIN directly, with Q=all ones, R=A, ERR=1, DONE two cycles after START edge, and BUSY high for one cycle.
REQ-026 SHALL, when SERIAL_DIVIDER_ZERO_TRAP_EN is undefined, tie ERR to 0 and run B=0 through the normal N+3-cycle sequence (REQ-021).

Verification
REQ-027 SHALL cover, with N=4: A=13, B=4, START pulse -> after N+3 cycles DONE=1, Q=3, R=1, ERR=0.
REQ-028 SHALL cover A=15, B=1 -> Q=15, R=0; and A=3, B=7 -> Q=0, R=3.
REQ-029 SHALL cover A=9, B=0 -> with macro: Q=15, R=9, ERR=1, DONE two cycles after START; without macro: Q=15, R=9, ERR=0, DONE after N+3 cycles.
REQ-030 SHALL cover START re-pulsed with A=1, B=1 during CALC of 13/4 -> ignored, result still Q=3, R=1, single DONE.
REQ-031 SHALL cover RESETN pulsed low in mid-CALC -> outputs 0 immediately, no DONE; following START 6/2 -> Q=3, R=0.
REQ-032 SHALL cover an exhaustive sweep of all 256 A/B pairs, back-to-back, checked against A/B and A%B (B nonzero).

Source files
------------

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - N-bit restoring serial divider, one quotient bit per cycle.
// Optional divide-by-zero trap: define SERIAL_DIVIDER_ZERO_TRAP_EN.
`timescale 1ns/1ps
module serial_divider #(
   parameter int N = 4
) (
   input  logic         CLOCK_50,
   input  logic         RESETN,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         BUSY,
   output logic         DONE,
   output logic         ERR
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, FIN} state_t;

   state_t        state_q;
   logic [N:0]    p_q;
   logic [N-1:0]  sh_q;
   logic [N-1:0]  div_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  r_q;
   logic          busy_q;
   logic          done_q;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
   logic          err_q;
   logic          zero_q;
`endif

   logic [N:0]    p_shift;
   logic          fits;
   logic [N:0]    p_d;
   logic [N-1:0]  sh_d;

   // p_q[N] is always clear after a step; it only makes the compare robust.
   always_comb begin
      p_shift = {p_q[N-1:0], sh_q[N-1]};
      fits    = p_q[N] | (p_shift >= {1'b0, div_q});
      p_d     = fits ? (p_shift - {1'b0, div_q}) : p_shift;
      sh_d    = {sh_q[N-2:0], fits};
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         p_q     <= '0;
         sh_q    <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START) begin
                  sh_q   <= A;
                  div_q  <= B;
                  busy_q <= 1'b1;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
                  err_q  <= 1'b0;
                  zero_q <= (B == '0);
                  state_q <= (B == '0) ? FIN : LOAD;
`else
                  state_q <= LOAD;
`endif
               end
            end
            LOAD: begin
               p_q     <= '0;
               cnt_q   <= '0;
               state_q <= CALC;
            end
            CALC: begin
               p_q   <= p_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= FIN;
               end
            end
            FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
               // Trapped divide: sh_q still holds the captured dividend.
               if (zero_q) begin
                  q_q   <= '1;
                  r_q   <= sh_q;
                  err_q <= 1'b1;
               end else begin
                  q_q <= sh_q;
                  r_q <= p_q[N-1:0];
               end
`else
               q_q <= sh_q;
               r_q <= p_q[N-1:0];
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
   assign ERR  = err_q;
`else
   assign ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - self-checking bench for serial_divider with a timeline model.
`timescale 1ns/1ps
module tb_serial_divider;
   localparam int N = 4;
`ifdef SERIAL_DIVIDER_ZERO_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic         CLOCK_50 = 1'b0;
   logic         RESETN   = 1'b1;
   logic         START    = 1'b0;
   logic [N-1:0] A        = '0;
   logic [N-1:0] B        = '0;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         BUSY;
   logic         DONE;
   logic         ERR;

   int n_checks = 0;
   int n_fail   = 0;

   serial_divider #(.N(N)) dut (
      .CLOCK_50(CLOCK_50), .RESETN(RESETN), .START(START), .A(A), .B(B),
      .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Timeline model: each accepted division yields its arithmetic result
   // after a fixed number of edges; outputs hold between results.
   logic [N-1:0] m_q = '0, m_r = '0, pq = '0, pr = '0;
   bit m_err = 0, m_busy = 0, m_done = 0, perr = 0, pending = 0;
   int done_at = -1, busy_end = -1, cyc = 0;

   initial forever begin
      @(posedge CLOCK_50);
      cyc++;
      if (!RESETN) begin
         pending = 0; done_at = -1;
         m_q = '0; m_r = '0; m_err = 0; m_busy = 0; m_done = 0;
      end else begin
         bit acc, trapped;
         acc = START && !pending && (cyc > done_at);
         m_done = 0;
         if (pending && cyc == done_at) begin
            m_q = pq; m_r = pr; m_err = perr; m_done = 1; pending = 0;
         end
         if (acc) begin
            trapped  = TRAP && (B == '0);
            pq       = (B == '0) ? '1 : A / B;
            pr       = (B == '0) ? A : A % B;
            perr     = trapped;
            m_err    = 0;
            pending  = 1;
            done_at  = cyc + (trapped ? 1 : N + 2);
            busy_end = trapped ? cyc : cyc + N;
         end
         m_busy = pending && (cyc <= busy_end);
      end
   end

   initial forever begin
      @(negedge CLOCK_50);
      chk("Q",    int'(Q),    int'(m_q));
      chk("R",    int'(R),    int'(m_r));
      chk("BUSY", int'(BUSY), int'(m_busy));
      chk("DONE", int'(DONE), int'(m_done));
      chk("ERR",  int'(ERR),  int'(m_err));
   end

   task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] q_lit, input logic [N-1:0] r_lit,
                         input bit err_lit, input int lat);
      int n;
      bit got;
      @(negedge CLOCK_50);
      #2 A = a; B = b; START = 1'b1;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge CLOCK_50);
         n++;
         if (DONE) got = 1;
         else #2 START = 1'b0;
      end
      START = 1'b0;
      chk({nm, "_latency"}, n, lat);
      chk({nm, "_Q"}, int'(Q), int'(q_lit));
      chk({nm, "_R"}, int'(R), int'(r_lit));
      chk({nm, "_ERR"}, int'(ERR), int'(err_lit));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones, n;
      bit got;
      #1 RESETN = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      #2 RESETN = 1'b1;
      chk("reset_Q", int'(Q), 0);
      chk("reset_R", int'(R), 0);
      chk("reset_BUSY", int'(BUSY), 0);
      chk("reset_DONE", int'(DONE), 0);
      chk("reset_ERR", int'(ERR), 0);

      run_op("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, N + 3);
      run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, N + 3);
      run_op("d3_7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, N + 3);
      run_op("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, TRAP, TRAP ? 2 : N + 3);

      // START re-pulsed during CALC with different operands must be ignored
      @(negedge CLOCK_50);
      #2 A = 4'd13; B = 4'd4; START = 1'b1;
      @(negedge CLOCK_50);
      #2 START = 1'b0; A = 4'd1; B = 4'd1;
      repeat (2) @(negedge CLOCK_50);
      #2 START = 1'b1;
      @(negedge CLOCK_50);
      #2 START = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge CLOCK_50);
         if (DONE) begin
            dones++;
            chk("ign_Q", int'(Q), 3);
            chk("ign_R", int'(R), 1);
         end
      end
      chk("ign_done_count", dones, 1);

      // reset in the middle of CALC
      @(negedge CLOCK_50);
      #2 A = 4'd13; B = 4'd4; START = 1'b1;
      @(negedge CLOCK_50);
      #2 START = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      #2 RESETN = 1'b0;
      #1;
      chk("midrst_Q", int'(Q), 0);
      chk("midrst_R", int'(R), 0);
      chk("midrst_BUSY", int'(BUSY), 0);
      chk("midrst_DONE", int'(DONE), 0);
      chk("midrst_ERR", int'(ERR), 0);
      @(negedge CLOCK_50);
      #2 RESETN = 1'b1;
      dones = 0;
      repeat (10) begin
         @(negedge CLOCK_50);
         if (DONE) dones++;
      end
      chk("midrst_no_done", dones, 0);
      run_op("d6_2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0, N + 3);

      // exhaustive back-to-back sweep, operands scrambled while busy
      @(negedge CLOCK_50);
      for (int idx = 0; idx < 256; idx++) begin
         #2 A = N'(idx / 16); B = N'(idx % 16); START = 1'b1;
         n = 0; got = 0;
         while (!got && n < 20) begin
            @(negedge CLOCK_50);
            n++;
            if (DONE) got = 1;
            else #2 begin A = N'($urandom); B = N'($urandom); end
         end
         chk("sweep_done_seen", int'(got), 1);
      end
      #2 START = 1'b0;
      repeat (12) @(negedge CLOCK_50);

      // random START / operands with sparse resets
      repeat (600) begin
         @(negedge CLOCK_50);
         #2 START = 1'($urandom_range(0, 1));
         A = N'($urandom);
         B = N'($urandom);
         RESETN = ($urandom_range(0, 149) != 0);
      end
      @(negedge CLOCK_50);
      #2 RESETN = 1'b1; START = 1'b0;
      repeat (12) @(negedge CLOCK_50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
